// File: rtl/exc_commit.sv
// Exception/ERET commit stage: picks one event per MEM instruction by fixed priority,
// strobes cp0, flushes the pipe, offers a redirect PC to fetch and then drains.
// Optional commit counters are built only when EXC_COMMIT_CNT_EN is defined.
`timescale 1ns/1ps
module exc_commit #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_stall,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic [31:0] mem_daddr,
    input  logic        mem_adel_if,
    input  logic        mem_ri,
    input  logic        mem_ov,
    input  logic        mem_sys,
    input  logic        mem_bp,
    input  logic        mem_adel_ld,
    input  logic        mem_ades_st,
    input  logic        mem_eret,
    input  logic        int_response,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic [4:0]  exc_excode,
    output logic        exc_bd,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_badvaddr,
    output logic        exc_eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic [31:0] exc_count,
    output logic [31:0] int_count
);

    typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;

    localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        int_pend_reg;
    logic [3:0]  drain_cnt_reg, drain_cnt_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;

    logic any_fault;
    logic commit;
    logic is_eret;

    // resetn gates commit so the combinational strobes read 0 while reset is held
    assign any_fault = int_pend_reg | mem_adel_if | mem_ri | mem_ov | mem_sys |
                       mem_bp | mem_adel_ld | mem_ades_st;
    assign commit    = resetn && (state_reg == IDLE) && mem_valid && !mem_stall &&
                       (any_fault || mem_eret);
    assign is_eret   = !any_fault && mem_eret;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            int_pend_reg    <= 1'b0;
            drain_cnt_reg   <= 4'd0;
            redirect_pc_reg <= 32'd0;
        end else begin
            state_reg       <= state_next;
            int_pend_reg    <= int_response;
            drain_cnt_reg   <= drain_cnt_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        drain_cnt_next   = drain_cnt_reg;
        redirect_pc_next = redirect_pc_reg;
        case (state_reg)
            IDLE: begin
                if (commit) begin
                    state_next       = REDIR;
                    redirect_pc_next = is_eret ? cp0_epc : EXC_VECTOR;
                end
            end
            REDIR: begin
                if (redirect_ready) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next     = DRAIN;
                        drain_cnt_next = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Commit payload is driven only in the commit cycle; zero otherwise
    always_comb begin
        exc_valid    = commit;
        exc_excode   = 5'h00;
        exc_bd       = 1'b0;
        exc_epc      = 32'd0;
        exc_badvaddr = 32'd0;
        exc_eret     = 1'b0;
        if (commit) begin
            if (is_eret) begin
                exc_eret = 1'b1;
                exc_epc  = mem_pc;
            end else begin
                exc_bd  = mem_bd;
                exc_epc = mem_bd ? (mem_pc - 32'd4) : mem_pc;
                if (int_pend_reg) begin
                    exc_excode = 5'h00;
                end else if (mem_adel_if) begin
                    exc_excode   = 5'h04;
                    exc_badvaddr = mem_pc;
                end else if (mem_ri) begin
                    exc_excode = 5'h0A;
                end else if (mem_ov) begin
                    exc_excode = 5'h0C;
                end else if (mem_sys) begin
                    exc_excode = 5'h08;
                end else if (mem_bp) begin
                    exc_excode = 5'h09;
                end else if (mem_adel_ld) begin
                    exc_excode   = 5'h04;
                    exc_badvaddr = mem_daddr;
                end else begin
                    exc_excode   = 5'h05;
                    exc_badvaddr = mem_daddr;
                end
            end
        end
    end

    assign flush          = commit || (state_reg != IDLE);
    assign redirect_valid = (state_reg == REDIR);
    assign redirect_pc    = redirect_pc_reg;

`ifdef EXC_COMMIT_CNT_EN
    logic [31:0] exc_count_reg;
    logic [31:0] int_count_reg;

    // An interrupt always wins priority, so int_pend at commit marks an interrupt commit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_count_reg <= 32'd0;
            int_count_reg <= 32'd0;
        end else begin
            if (commit && !is_eret) exc_count_reg <= exc_count_reg + 32'd1;
            if (commit && int_pend_reg) int_count_reg <= int_count_reg + 32'd1;
        end
    end

    assign exc_count = exc_count_reg;
    assign int_count = int_count_reg;
`else
    assign exc_count = 32'd0;
    assign int_count = 32'd0;
`endif

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: commit decode, redirect handshake, drain and reset behaviour.
`timescale 1ns/1ps
module tb_exc_commit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_stall, mem_bd;
    logic [31:0] mem_pc, mem_daddr, cp0_epc;
    logic        mem_adel_if, mem_ri, mem_ov, mem_sys, mem_bp, mem_adel_ld, mem_ades_st, mem_eret;
    logic        int_response, redirect_ready;
    logic        exc_valid, exc_bd, exc_eret, flush, redirect_valid;
    logic [4:0]  exc_excode;
    logic [31:0] exc_epc, exc_badvaddr, redirect_pc, exc_count, int_count;

    int checks   = 0;
    int failures = 0;

    exc_commit dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_pc(mem_pc), .mem_bd(mem_bd),
        .mem_daddr(mem_daddr), .mem_adel_if(mem_adel_if), .mem_ri(mem_ri), .mem_ov(mem_ov),
        .mem_sys(mem_sys), .mem_bp(mem_bp), .mem_adel_ld(mem_adel_ld), .mem_ades_st(mem_ades_st),
        .mem_eret(mem_eret), .int_response(int_response), .cp0_epc(cp0_epc),
        .exc_valid(exc_valid), .exc_excode(exc_excode), .exc_bd(exc_bd), .exc_epc(exc_epc),
        .exc_badvaddr(exc_badvaddr), .exc_eret(exc_eret), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .exc_count(exc_count), .int_count(int_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_valid = 0; mem_stall = 0; mem_bd = 0; mem_pc = 0; mem_daddr = 0;
        mem_adel_if = 0; mem_ri = 0; mem_ov = 0; mem_sys = 0; mem_bp = 0;
        mem_adel_ld = 0; mem_ades_st = 0; mem_eret = 0; int_response = 0;
        cp0_epc = 0; redirect_ready = 0;
    endtask

    // Called in the first REDIR cycle; leaves the DUT back in IDLE
    task automatic drain_out();
        redirect_ready = 1;
        step();
        redirect_ready = 0;
        step();
        step();
        check("idle_flush", {31'd0, flush}, 32'd0);
    endtask

    task automatic expect_commit(input string tag, input logic [4:0] code,
                                 input logic [31:0] epc, input logic bd,
                                 input logic [31:0] bva);
        #2;
        check({tag, "_valid"}, {31'd0, exc_valid}, 32'd1);
        check({tag, "_excode"}, {27'd0, exc_excode}, {27'd0, code});
        check({tag, "_epc"}, exc_epc, epc);
        check({tag, "_bd"}, {31'd0, exc_bd}, {31'd0, bd});
        check({tag, "_badvaddr"}, exc_badvaddr, bva);
        check({tag, "_eret"}, {31'd0, exc_eret}, 32'd0);
        check({tag, "_flush"}, {31'd0, flush}, 32'd1);
    endtask

    initial begin
        clear_inputs();
        resetn = 0;
        mem_valid = 1; mem_ov = 1; mem_pc = 32'h8000_1000;
        #3;
        check("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redir_pc", redirect_pc, 32'd0);
        check("rst_excode", {27'd0, exc_excode}, 32'd0);
        check("rst_exc_count", exc_count, 32'd0);
        clear_inputs();
        #20 resetn = 1;
        step();

        // Overflow, then a second fault offered while busy is dropped
        mem_valid = 1; mem_ov = 1; mem_pc = 32'h8000_1000;
        expect_commit("ov", 5'h0C, 32'h8000_1000, 1'b0, 32'd0);
        check("ov_redir_valid_c0", {31'd0, redirect_valid}, 32'd0);
        step();
        clear_inputs();
        mem_valid = 1; mem_ri = 1; mem_pc = 32'h8000_1004;
        #2;
        check("ov_redir_valid", {31'd0, redirect_valid}, 32'd1);
        check("ov_redir_pc", redirect_pc, 32'hBFC0_0380);
        check("busy_redir_no_exc", {31'd0, exc_valid}, 32'd0);
        redirect_ready = 1;
        step();
        redirect_ready = 0;
        #2;
        check("drain1_flush", {31'd0, flush}, 32'd1);
        check("drain1_redir_valid", {31'd0, redirect_valid}, 32'd0);
        check("busy_drain_no_exc", {31'd0, exc_valid}, 32'd0);
        step();
        check("drain2_flush", {31'd0, flush}, 32'd1);
        clear_inputs();
        step();
        check("ov_idle_flush", {31'd0, flush}, 32'd0);

        // Delay-slot store fault
        mem_valid = 1; mem_ades_st = 1; mem_bd = 1; mem_pc = 32'h8000_2004; mem_daddr = 32'h1003;
        expect_commit("st", 5'h05, 32'h8000_2000, 1'b1, 32'h1003);
        step();
        clear_inputs();
        drain_out();

        // Pending interrupt beats fetch fault and ERET
        int_response = 1;
        step();
        int_response = 0;
        mem_valid = 1; mem_adel_if = 1; mem_eret = 1; mem_pc = 32'h8000_3000;
        expect_commit("int", 5'h00, 32'h8000_3000, 1'b0, 32'd0);
        step();
        clear_inputs();
        drain_out();

        // Fetch address error reports the PC as bad address
        mem_valid = 1; mem_adel_if = 1; mem_pc = 32'h8000_4002; mem_daddr = 32'h55;
        expect_commit("adel_if", 5'h04, 32'h8000_4002, 1'b0, 32'h8000_4002);
        step();
        clear_inputs();
        drain_out();

        // Break beats load address error
        mem_valid = 1; mem_bp = 1; mem_adel_ld = 1; mem_pc = 32'h8000_5000; mem_daddr = 32'h2001;
        expect_commit("bp", 5'h09, 32'h8000_5000, 1'b0, 32'd0);
        step();
        clear_inputs();
        drain_out();

        // Stall blocks commit until released
        mem_valid = 1; mem_sys = 1; mem_stall = 1; mem_pc = 32'h8000_6000;
        #2;
        check("stall_no_exc", {31'd0, exc_valid}, 32'd0);
        check("stall_no_flush", {31'd0, flush}, 32'd0);
        step();
        check("stall2_no_exc", {31'd0, exc_valid}, 32'd0);
        mem_stall = 0;
        expect_commit("sys", 5'h08, 32'h8000_6000, 1'b0, 32'd0);
        step();
        clear_inputs();
        drain_out();

        // ERET with redirect held off for 3 cycles
        mem_valid = 1; mem_eret = 1; mem_bd = 1; mem_pc = 32'h8000_0100; cp0_epc = 32'h8000_0040;
        #2;
        check("eret_valid", {31'd0, exc_valid}, 32'd1);
        check("eret_flag", {31'd0, exc_eret}, 32'd1);
        check("eret_excode", {27'd0, exc_excode}, 32'd0);
        check("eret_epc", exc_epc, 32'h8000_0100);
        check("eret_bd", {31'd0, exc_bd}, 32'd0);
        step();
        clear_inputs();
        cp0_epc = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("eret_hold_valid", {31'd0, redirect_valid}, 32'd1);
            check("eret_hold_pc", redirect_pc, 32'h8000_0040);
            check("eret_hold_flush", {31'd0, flush}, 32'd1);
            step();
        end
        redirect_ready = 1;
        #1;
        step();
        redirect_ready = 0;
        check("eret_drain1_flush", {31'd0, flush}, 32'd1);
        check("eret_drain1_rv", {31'd0, redirect_valid}, 32'd0);
        step();
        check("eret_drain2_flush", {31'd0, flush}, 32'd1);
        step();
        check("eret_idle_flush", {31'd0, flush}, 32'd0);

`ifdef EXC_COMMIT_CNT_EN
        check("exc_count", exc_count, 32'd6);
        check("int_count", int_count, 32'd1);
`else
        check("exc_count_off", exc_count, 32'd0);
        check("int_count_off", int_count, 32'd0);
`endif

        // Reset asserted mid-DRAIN
        mem_valid = 1; mem_ri = 1; mem_pc = 32'h8000_7000;
        expect_commit("ri", 5'h0A, 32'h8000_7000, 1'b0, 32'd0);
        step();
        clear_inputs();
        redirect_ready = 1;
        step();
        redirect_ready = 0;
        check("pre_rst_flush", {31'd0, flush}, 32'd1);
        resetn = 0;
        #1;
        check("mid_rst_flush", {31'd0, flush}, 32'd0);
        check("mid_rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("mid_rst_pc", redirect_pc, 32'd0);
        check("mid_rst_exc_count", exc_count, 32'd0);
        step();
        resetn = 1;
        step();
        mem_valid = 1; mem_ov = 1; mem_pc = 32'h8000_8000;
        expect_commit("post_rst", 5'h0C, 32'h8000_8000, 1'b0, 32'd0);
        step();
        clear_inputs();
        drain_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
